// File: rtl/jt900h_pkg.sv
// Shared definitions for the JT900H micro-DMA engine: register field codes,
// step/size encodings, the engine FSM states and a pointer-step helper.
package jt900h_pkg;

    typedef enum logic [1:0] {
        FLD_SRC  = 2'd0,
        FLD_DST  = 2'd1,
        FLD_CNT  = 2'd2,
        FLD_MODE = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        STEP_FIX  = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2,
        STEP_FIX3 = 2'd3
    } step_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_RD2,
        ST_WR,
        ST_WR2,
        ST_UPD
    } state_e;

    localparam int ADDR_W = 24;
    localparam int MODE_W = 6;

    // Channel index width, kept at least one bit so CH=1 still has a legal vector.
    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    function automatic logic [ADDR_W-1:0] step_ptr(input logic [ADDR_W-1:0] p,
                                                   input logic [1:0]        step,
                                                   input logic [2:0]        amt);
        logic [ADDR_W-1:0] r;
        r = p;
        case (step_e'(step))
            STEP_INC: r = p + ADDR_W'(amt);
            STEP_DEC: r = p - ADDR_W'(amt);
            default:  r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jt900h_mdma_if.sv
// Bus-borrowing port of the micro-DMA engine: request/grant handshake plus
// the external address/data/byte-enable/wait signals.
interface jt900h_mdma_if;
    logic        dma_req;
    logic        dma_gnt;
    logic [23:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic [1:0]  we;
    logic        busy;

    modport master (output dma_req, addr, dout, we,
                    input  dma_gnt, din, busy);

    modport slave  (input  dma_req, addr, dout, we,
                    output dma_gnt, din, busy);
endinterface

// File: rtl/jt900h_mdma_arb.sv
// Combinational fixed-priority picker: lowest requesting channel index wins.
module jt900h_mdma_arb
    import jt900h_pkg::*;
#(
    parameter  int CH  = 4,
    localparam int CHW = ch_idx_w(CH)
) (
    input  logic [CH-1:0]  req_i,
    output logic [CHW-1:0] idx_o,
    output logic           valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan downwards so the last (lowest) hit overrides higher ones.
        for (int i = CH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = CHW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt900h_mdma.sv
// Multi-channel micro-DMA engine: per-channel SRC/DST/CNT/MODE registers, one
// byte/word/long move per request. Define JT900H_MDMA_LONG_EN for 32-bit moves.
module jt900h_mdma
    import jt900h_pkg::*;
#(
    parameter int CH = 4,
    parameter int CW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic [31:0]            regin,
    input  logic [$clog2(CH)+1:0]  regsel,
    input  logic                   regwe,
    output logic [31:0]            regout,
    input  logic [CH-1:0]          dreq,
    output logic [CH-1:0]          tc,
    jt900h_mdma_if.master          bus
);

    localparam int CHW = ch_idx_w(CH);
`ifdef JT900H_MDMA_LONG_EN
    localparam int DW = 32;
`else
    localparam int DW = 16;
`endif

    logic [ADDR_W-1:0] src_a  [CH];
    logic [ADDR_W-1:0] dst_a  [CH];
    logic [CW-1:0]     cnt_a  [CH];
    logic [MODE_W-1:0] mode_a [CH];
    logic [CH-1:0]     armed;

    state_e         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [DW-1:0]  data_q, data_d;
    logic [CH-1:0]  tc_q, tc_d;

    logic [CHW-1:0] sel_ch;
    logic [1:0]     sel_fld;
    logic           sel_ok;
    logic           unused_regin;

    logic [CHW-1:0] arb_idx;
    logic           arb_valid;

    logic [ADDR_W-1:0] cur_src, cur_dst, src_upd, dst_upd;
    logic [CW-1:0]     cur_cnt, cnt_upd;
    logic [MODE_W-1:0] cur_mode;
    logic              is_byte, is_long, cnt_wr_now;
    logic [2:0]        amt;

    assign sel_fld      = regsel[1:0];
    assign sel_ok       = int'(sel_ch) < CH;
    assign unused_regin = ^regin;

    generate
        if (CH > 1) begin : g_sel
            assign sel_ch = regsel[$clog2(CH)+1:2];
        end else begin : g_sel1
            assign sel_ch = '0;
        end
    endgenerate

    jt900h_mdma_arb #(.CH(CH)) u_arb (
        .req_i   (dreq & armed),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Per-channel register file; a host write in the UPD cycle beats the update.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [ADDR_W-1:0] src_q, dst_q;
            logic [CW-1:0]     cnt_q;
            logic [MODE_W-1:0] mode_q;
            logic              wr_hit, upd_hit;

            assign wr_hit  = regwe && (sel_ch == CHW'(gi));
            assign upd_hit = (state_q == ST_UPD) && (ch_q == CHW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    src_q  <= '0;
                    dst_q  <= '0;
                    cnt_q  <= '0;
                    mode_q <= '0;
                end else if (cen) begin
                    if (wr_hit && sel_fld == FLD_SRC)       src_q <= regin[ADDR_W-1:0];
                    else if (upd_hit)                       src_q <= src_upd;
                    if (wr_hit && sel_fld == FLD_DST)       dst_q <= regin[ADDR_W-1:0];
                    else if (upd_hit)                       dst_q <= dst_upd;
                    if (wr_hit && sel_fld == FLD_CNT)       cnt_q <= regin[CW-1:0];
                    else if (upd_hit)                       cnt_q <= cnt_upd;
                    if (wr_hit && sel_fld == FLD_MODE)      mode_q <= regin[MODE_W-1:0];
                end
            end

            assign src_a[gi]  = src_q;
            assign dst_a[gi]  = dst_q;
            assign cnt_a[gi]  = cnt_q;
            assign mode_a[gi] = mode_q;
            assign armed[gi]  = (cnt_q != '0);
        end
    endgenerate

    always_comb begin
        regout = '0;
        if (sel_ok) begin
            case (field_e'(sel_fld))
                FLD_SRC:  regout = {8'd0, src_a[sel_ch]};
                FLD_DST:  regout = {8'd0, dst_a[sel_ch]};
                FLD_CNT:  regout = 32'(cnt_a[sel_ch]);
                default:  regout = {{(32-MODE_W){1'b0}}, mode_a[sel_ch]};
            endcase
        end
    end

    assign cur_src  = src_a[ch_q];
    assign cur_dst  = dst_a[ch_q];
    assign cur_cnt  = cnt_a[ch_q];
    assign cur_mode = mode_a[ch_q];

    always_comb begin
        is_byte = (cur_mode[1:0] == SZ_BYTE) || (cur_mode[1:0] == SZ_RSVD);
`ifdef JT900H_MDMA_LONG_EN
        is_long = (cur_mode[1:0] == SZ_LONG);
`else
        is_long = 1'b0;
`endif
        amt = is_byte ? 3'd1 : (is_long ? 3'd4 : 3'd2);
    end

    assign src_upd    = step_ptr(cur_src, cur_mode[3:2], amt);
    assign dst_upd    = step_ptr(cur_dst, cur_mode[5:4], amt);
    // A count cleared by the host mid-transfer stays at zero rather than wrapping.
    assign cnt_upd    = (cur_cnt == '0) ? '0 : cur_cnt - 1'b1;
    assign cnt_wr_now = regwe && sel_ok && (sel_ch == ch_q) && (sel_fld == FLD_CNT);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        data_d  = data_q;
        tc_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    ch_d    = arb_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.dma_gnt) state_d = ST_RD;
            end
            ST_RD: begin
                if (!bus.busy) begin
                    if (is_byte) data_d[7:0]  = cur_src[0] ? bus.din[15:8] : bus.din[7:0];
                    else         data_d[15:0] = bus.din;
`ifdef JT900H_MDMA_LONG_EN
                    state_d = is_long ? ST_RD2 : ST_WR;
`else
                    state_d = ST_WR;
`endif
                end
            end
`ifdef JT900H_MDMA_LONG_EN
            ST_RD2: begin
                if (!bus.busy) begin
                    data_d[31:16] = bus.din;
                    state_d       = ST_WR;
                end
            end
            ST_WR2: begin
                if (!bus.busy) state_d = ST_UPD;
            end
`endif
            ST_WR: begin
                if (!bus.busy) begin
`ifdef JT900H_MDMA_LONG_EN
                    state_d = is_long ? ST_WR2 : ST_UPD;
`else
                    state_d = ST_UPD;
`endif
                end
            end
            ST_UPD: begin
                if (cur_cnt == CW'(1) && !cnt_wr_now) tc_d[ch_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            data_q  <= '0;
            tc_q    <= '0;
        end else if (cen) begin
            state_q <= state_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            tc_q    <= tc_d;
        end
    end

    assign tc = tc_q;

    // Bus drive is decoded from the state register, so it holds steady during waits.
    always_comb begin
        bus.dma_req = (state_q == ST_REQ) || (state_q == ST_RD) || (state_q == ST_RD2) ||
                      (state_q == ST_WR)  || (state_q == ST_WR2);
        bus.addr    = '0;
        bus.dout    = '0;
        bus.we      = 2'b00;
        case (state_q)
            ST_RD: bus.addr = is_byte ? cur_src : {cur_src[ADDR_W-1:1], 1'b0};
            ST_WR: begin
                if (is_byte) begin
                    bus.addr = cur_dst;
                    bus.dout = {2{data_q[7:0]}};
                    bus.we   = cur_dst[0] ? 2'b10 : 2'b01;
                end else begin
                    bus.addr = {cur_dst[ADDR_W-1:1], 1'b0};
                    bus.dout = data_q[15:0];
                    bus.we   = 2'b11;
                end
            end
`ifdef JT900H_MDMA_LONG_EN
            ST_RD2: bus.addr = {cur_src[ADDR_W-1:1] + 1'b1, 1'b0};
            ST_WR2: begin
                bus.addr = {cur_dst[ADDR_W-1:1] + 1'b1, 1'b0};
                bus.dout = data_q[31:16];
                bus.we   = 2'b11;
            end
`endif
            default: ;
        endcase
    end

endmodule
